// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_stage -- Memory stage of the RisKy1 5-stage pipeline.
//
// Takes one instruction at a time from Execute (valid/rdy). The stage either
// passes a non-memory result straight through, drops a misaligned access, or
// runs a load/store on the req/ack data-memory port. Loads get byte/half lane
// selection and sign/zero extension. Every instruction ends in a single-entry
// M2W output register that is held until WB takes it.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a REQ that sees no ack
// within DMEM_TIMEOUT cycles. This also adds the bus_err output.
//
// Ports:
//   clk_in, reset_in      clock, synchronous active-low reset
//   cpu_halt              blocks new accepts only
//   e2m_*                 instruction from Execute, e2m_rdy back to Execute
//   dmem_*                data-memory request port (word address, byte enables)
//   m2w_*                 result register towards Writeback
//   bus_err               (DMEM_TIMEOUT_EN only) one-cycle pulse on timeout abort
//   misalign              one-cycle pulse when a misaligned access is dropped
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int RSZ          = 32,
    parameter int MAX_GPR      = 32,
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic           clk_in,
    input  logic           reset_in,
    input  logic           cpu_halt,
    input  logic           e2m_valid,
    output logic           e2m_rdy,
    input  logic           e2m_Rd_wr,
    input  logic [4:0]     e2m_Rd_addr,
    input  logic [RSZ-1:0] e2m_Rd_data,
    input  logic           e2m_is_ld,
    input  logic           e2m_is_st,
    input  logic [1:0]     e2m_size,
    input  logic           e2m_unsigned,
    input  logic [RSZ-1:0] e2m_addr,
    input  logic [RSZ-1:0] e2m_st_data,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [RSZ-1:0] dmem_addr,
    output logic [3:0]     dmem_be,
    output logic [RSZ-1:0] dmem_wdata,
    input  logic           dmem_ack,
    input  logic [RSZ-1:0] dmem_rdata,
    output logic           m2w_valid,
    input  logic           m2w_rdy,
    output logic           m2w_Rd_wr,
    output logic [4:0]     m2w_Rd_addr,
    output logic [RSZ-1:0] m2w_Rd_data,
`ifdef DMEM_TIMEOUT_EN
    output logic           bus_err,
`endif
    output logic           misalign
);

    // Elaboration-time parameter checks
    if (RSZ != 32) begin : g_bad_rsz
        $fatal(1, "mem_stage: RSZ must be 32");
    end
    if (MAX_GPR != 16 && MAX_GPR != 32) begin : g_bad_gpr
        $fatal(1, "mem_stage: MAX_GPR must be 16 or 32");
    end
    if (DMEM_TIMEOUT < 1 || DMEM_TIMEOUT > 255) begin : g_bad_tmo
        $fatal(1, "mem_stage: DMEM_TIMEOUT must fit an 8-bit counter (1..255)");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Registered datapath
    logic           dmem_we_q;
    logic [RSZ-1:0] dmem_addr_q;
    logic [3:0]     dmem_be_q;
    logic [RSZ-1:0] dmem_wdata_q;
    logic           m2w_rd_wr_q;
    logic [4:0]     m2w_rd_addr_q;
    logic [RSZ-1:0] m2w_rd_data_q;
    logic           misalign_q;
    logic           is_ld_q;
    logic [1:0]     ld_size_q;
    logic           ld_unsigned_q;
    logic [1:0]     ld_lane_q;

    // Accept-side decode
    logic           accept;
    logic           in_is_mem;
    logic           in_misalign;
    logic           in_to_req;
    logic [3:0]     in_be;
    logic [RSZ-1:0] in_wdata;

    // Load-return path
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [RSZ-1:0] ld_result;

    logic           tmo_hit;

    assign accept    = e2m_valid & e2m_rdy;
    assign in_is_mem = e2m_is_ld | e2m_is_st;
    // size 3 is treated like a word access
    assign in_misalign = ((e2m_size == 2'd1) & e2m_addr[0])
                       | (e2m_size[1] & (e2m_addr[1:0] != 2'b00));
    assign in_to_req   = in_is_mem & ~in_misalign;

    // Byte-lane steering of the store: enables shifted to the addressed lane,
    // data replicated so every lane carries it.
    always_comb begin
        in_be    = 4'b1111;
        in_wdata = e2m_st_data;
        case (e2m_size)
            2'd0: begin
                in_be    = 4'b0001 << e2m_addr[1:0];
                in_wdata = {4{e2m_st_data[7:0]}};
            end
            2'd1: begin
                in_be    = 4'b0011 << e2m_addr[1:0];
                in_wdata = {2{e2m_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and extension. Half accesses are aligned, so only
    // lane bit 1 picks the half.
    assign ld_byte = dmem_rdata[{ld_lane_q, 3'b000} +: 8];
    assign ld_half = ld_lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        ld_result = dmem_rdata;
        case (ld_size_q)
            2'd0:    ld_result = {{(RSZ-8){~ld_unsigned_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_result = {{(RSZ-16){~ld_unsigned_q & ld_half[15]}}, ld_half};
            default: ld_result = dmem_rdata;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = in_to_req ? S_REQ : S_OUT;
            end
            S_REQ: begin
                if (dmem_ack || tmo_hit) state_d = S_OUT;
            end
            S_OUT: begin
                // accept here implies m2w_rdy: back-to-back without a bubble
                if (accept)       state_d = in_to_req ? S_REQ : S_OUT;
                else if (m2w_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        e2m_rdy     = reset_in & ~cpu_halt
                    & ((state_q == S_IDLE) | ((state_q == S_OUT) & m2w_rdy));
        dmem_req    = (state_q == S_REQ);
        m2w_valid   = (state_q == S_OUT);
        dmem_we     = dmem_we_q;
        dmem_addr   = dmem_addr_q;
        dmem_be     = dmem_be_q;
        dmem_wdata  = dmem_wdata_q;
        m2w_Rd_wr   = m2w_rd_wr_q;
        m2w_Rd_addr = m2w_rd_addr_q;
        m2w_Rd_data = m2w_rd_data_q;
        misalign    = misalign_q;
    end

    // ---------------- Datapath ----------------
    // The m2w fields are loaded at accept. They are only visible once the
    // state reaches OUT, and a load overwrites the data on ack.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_be_q     <= 4'b0000;
            dmem_wdata_q  <= '0;
            m2w_rd_wr_q   <= 1'b0;
            m2w_rd_addr_q <= 5'd0;
            m2w_rd_data_q <= '0;
            misalign_q    <= 1'b0;
            is_ld_q       <= 1'b0;
            ld_size_q     <= 2'd0;
            ld_unsigned_q <= 1'b0;
            ld_lane_q     <= 2'd0;
        end else begin
            misalign_q <= 1'b0;
            if (accept) begin
                m2w_rd_addr_q <= e2m_Rd_addr;
                m2w_rd_data_q <= e2m_Rd_data;
                // stores and dropped accesses never write a GPR
                m2w_rd_wr_q   <= e2m_Rd_wr & ~e2m_is_st & ~(in_is_mem & in_misalign);
                misalign_q    <= in_is_mem & in_misalign;
                if (in_to_req) begin
                    dmem_we_q     <= e2m_is_st;
                    dmem_addr_q   <= {e2m_addr[RSZ-1:2], 2'b00};
                    dmem_be_q     <= in_be;
                    dmem_wdata_q  <= in_wdata;
                    is_ld_q       <= ~e2m_is_st;
                    ld_size_q     <= e2m_size;
                    ld_unsigned_q <= e2m_unsigned;
                    ld_lane_q     <= e2m_addr[1:0];
                end
            end else if (state_q == S_REQ) begin
                if (dmem_ack) begin
                    if (is_ld_q) m2w_rd_data_q <= ld_result;
                end else if (tmo_hit) begin
                    m2w_rd_wr_q <= 1'b0;
                end
            end
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(DMEM_TIMEOUT);

    logic [7:0] tmo_cnt_q;
    logic [7:0] tmo_cnt_d;
    logic       bus_err_q;

    // Abort on the REQ cycle in which the no-ack count would reach the limit
    assign tmo_cnt_d = tmo_cnt_q + 8'd1;
    assign tmo_hit   = (state_q == S_REQ) & ~dmem_ack & (tmo_cnt_d == TMO_LIMIT);
    assign bus_err   = bus_err_q;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            tmo_cnt_q <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= tmo_hit;
            if (accept) begin
                tmo_cnt_q <= 8'd0;
            end else if ((state_q == S_REQ) && !dmem_ack) begin
                tmo_cnt_q <= tmo_cnt_d;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        cpu_halt;
    logic        e2m_valid;
    logic        e2m_rdy;
    logic        e2m_Rd_wr;
    logic [4:0]  e2m_Rd_addr;
    logic [31:0] e2m_Rd_data;
    logic        e2m_is_ld;
    logic        e2m_is_st;
    logic [1:0]  e2m_size;
    logic        e2m_unsigned;
    logic [31:0] e2m_addr;
    logic [31:0] e2m_st_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        m2w_valid;
    logic        m2w_rdy;
    logic        m2w_Rd_wr;
    logic [4:0]  m2w_Rd_addr;
    logic [31:0] m2w_Rd_data;
    logic        misalign;
`ifdef DMEM_TIMEOUT_EN
    logic        bus_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    mem_stage #(.RSZ(32), .MAX_GPR(32), .DMEM_TIMEOUT(4)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt),
        .e2m_valid(e2m_valid), .e2m_rdy(e2m_rdy), .e2m_Rd_wr(e2m_Rd_wr),
        .e2m_Rd_addr(e2m_Rd_addr), .e2m_Rd_data(e2m_Rd_data),
        .e2m_is_ld(e2m_is_ld), .e2m_is_st(e2m_is_st), .e2m_size(e2m_size),
        .e2m_unsigned(e2m_unsigned), .e2m_addr(e2m_addr), .e2m_st_data(e2m_st_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .m2w_valid(m2w_valid), .m2w_rdy(m2w_rdy),
        .m2w_Rd_wr(m2w_Rd_wr), .m2w_Rd_addr(m2w_Rd_addr), .m2w_Rd_data(m2w_Rd_data),
`ifdef DMEM_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .misalign(misalign)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_e2m();
        e2m_valid    = 1'b0;
        e2m_Rd_wr    = 1'b0;
        e2m_Rd_addr  = 5'd0;
        e2m_Rd_data  = 32'h0;
        e2m_is_ld    = 1'b0;
        e2m_is_st    = 1'b0;
        e2m_size     = 2'd0;
        e2m_unsigned = 1'b0;
        e2m_addr     = 32'h0;
        e2m_st_data  = 32'h0;
    endtask

    task automatic drive(input logic rd_wr, input logic [4:0] rd, input logic [31:0] data,
                         input logic ld, input logic st, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sdata);
        e2m_valid    = 1'b1;
        e2m_Rd_wr    = rd_wr;
        e2m_Rd_addr  = rd;
        e2m_Rd_data  = data;
        e2m_is_ld    = ld;
        e2m_is_st    = st;
        e2m_size     = size;
        e2m_unsigned = uns;
        e2m_addr     = addr;
        e2m_st_data  = sdata;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        drive(1'b1, 5'd3, 32'h1111_2222, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        dmem_ack = 1'b1;
        step();
        step();
        tests++; if (e2m_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b expected 0", e2m_rdy); end
        tests++; if ({m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data} !== 39'h0) begin fails++;
            $display("FAIL reset_m2w: got v=%b wr=%b rd=%0d data=%h expected all 0", m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data); end
        tests++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, misalign} !== 71'h0) begin fails++;
            $display("FAIL reset_dmem: got req=%b we=%b addr=%h be=%b wdata=%h mis=%b expected all 0", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, misalign); end
        clear_e2m();
        dmem_ack = 1'b0;
        reset_in = 1'b1;
        step();
        $display("[TB] reset checked");
    endtask

    task automatic test_alu();
        m2w_rdy = 1'b1;
        drive(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        #1;
        tests++; if (e2m_rdy !== 1'b1) begin fails++; $display("FAIL alu_rdy0: got %b expected 1", e2m_rdy); end
        step();
        tests++; if ({m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data} !== {1'b1, 1'b1, 5'd5, 32'h0000_1234}) begin fails++;
            $display("FAIL alu_out0: got v=%b wr=%b rd=%0d data=%h expected v=1 wr=1 rd=5 data=00001234", m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data); end
        // back-to-back: Rd_addr 0 passes through unchanged
        drive(1'b1, 5'd0, 32'hA5A5_0001, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        #1;
        tests++; if (e2m_rdy !== 1'b1) begin fails++; $display("FAIL alu_rdy1: got %b expected 1", e2m_rdy); end
        step();
        tests++; if ({m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data} !== {1'b1, 1'b1, 5'd0, 32'hA5A5_0001}) begin fails++;
            $display("FAIL alu_out1: got v=%b wr=%b rd=%0d data=%h expected v=1 wr=1 rd=0 data=a5a50001", m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data); end
        // non-memory op with an odd address field must not flag misalign
        drive(1'b0, 5'd31, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd2, 1'b0, 32'h3, 32'h0);
        #1;
        tests++; if (e2m_rdy !== 1'b1) begin fails++; $display("FAIL alu_rdy2: got %b expected 1", e2m_rdy); end
        step();
        tests++; if ({m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data, misalign} !== {1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF, 1'b0}) begin fails++;
            $display("FAIL alu_out2: got v=%b wr=%b rd=%0d data=%h mis=%b expected v=1 wr=0 rd=31 data=deadbeef mis=0", m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data, misalign); end
        clear_e2m();
        step();
        tests++; if (m2w_valid !== 1'b0) begin fails++; $display("FAIL alu_idle: m2w_valid got %b expected 0", m2w_valid); end
        $display("[TB] alu back-to-back checked");
    endtask

    task automatic test_load(input string name, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] rdata, input int wait_n,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_data);
        m2w_rdy = 1'b1;
        drive(1'b1, 5'd7, 32'h5555_5555, 1'b1, 1'b0, size, uns, addr, 32'h0);
        step();
        clear_e2m();
        for (int i = 0; i < wait_n; i++) begin
            tests++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, e2m_rdy} !== {1'b1, 1'b0, exp_addr, exp_be, 1'b0}) begin fails++;
                $display("FAIL %s_req%0d: got req=%b we=%b addr=%h be=%b rdy=%b expected req=1 we=0 addr=%h be=%b rdy=0",
                         name, i, dmem_req, dmem_we, dmem_addr, dmem_be, e2m_rdy, exp_addr, exp_be); end
            if (i == wait_n - 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            step();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        tests++; if ({m2w_valid, dmem_req, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data} !== {1'b1, 1'b0, 1'b1, 5'd7, exp_data}) begin fails++;
            $display("FAIL %s_out: got v=%b req=%b wr=%b rd=%0d data=%h expected v=1 req=0 wr=1 rd=7 data=%h",
                     name, m2w_valid, dmem_req, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data, exp_data); end
        step();
        tests++; if (m2w_valid !== 1'b0) begin fails++; $display("FAIL %s_idle: m2w_valid got %b expected 0", name, m2w_valid); end
        $display("[TB] %s addr=%h data=%h", name, addr, exp_data);
    endtask

    task automatic test_store(input string name, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] sdata, input int wait_n, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        m2w_rdy = 1'b1;
        drive(1'b1, 5'd12, 32'h0BAD_F00D, 1'b0, 1'b1, size, 1'b0, addr, sdata);
        step();
        clear_e2m();
        for (int i = 0; i < wait_n; i++) begin
            tests++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, exp_addr, exp_be, exp_wdata}) begin fails++;
                $display("FAIL %s_req%0d: got req=%b we=%b addr=%h be=%b wdata=%h expected req=1 we=1 addr=%h be=%b wdata=%h",
                         name, i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, exp_addr, exp_be, exp_wdata); end
            if (i == wait_n - 1) dmem_ack = 1'b1;
            step();
        end
        dmem_ack = 1'b0;
        tests++; if ({m2w_valid, m2w_Rd_wr, dmem_req} !== 3'b100) begin fails++;
            $display("FAIL %s_out: got v=%b wr=%b req=%b expected v=1 wr=0 req=0", name, m2w_valid, m2w_Rd_wr, dmem_req); end
        step();
        $display("[TB] %s addr=%h wdata=%h", name, addr, exp_wdata);
    endtask

    task automatic test_misalign(input string name, input logic [1:0] size, input logic [31:0] addr);
        m2w_rdy = 1'b1;
        drive(1'b1, 5'd4, 32'h7777_0000, 1'b1, 1'b0, size, 1'b0, addr, 32'h0);
        step();
        clear_e2m();
        dmem_ack = 1'b1;  // stray ack outside REQ must be ignored
        tests++; if ({dmem_req, misalign, m2w_valid, m2w_Rd_wr} !== 4'b0110) begin fails++;
            $display("FAIL %s_out: got req=%b mis=%b v=%b wr=%b expected req=0 mis=1 v=1 wr=0", name, dmem_req, misalign, m2w_valid, m2w_Rd_wr); end
        step();
        dmem_ack = 1'b0;
        tests++; if ({dmem_req, misalign, m2w_valid} !== 3'b000) begin fails++;
            $display("FAIL %s_after: got req=%b mis=%b v=%b expected all 0", name, dmem_req, misalign, m2w_valid); end
        $display("[TB] %s addr=%h dropped", name, addr);
    endtask

    task automatic test_stall_halt();
        m2w_rdy = 1'b0;
        drive(1'b1, 5'd9, 32'h0000_CAFE, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        step();
        cpu_halt = 1'b1;
        drive(1'b1, 5'd10, 32'h0000_1111, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++; if ({m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data, e2m_rdy} !== {1'b1, 1'b1, 5'd9, 32'h0000_CAFE, 1'b0}) begin fails++;
                $display("FAIL stall%0d: got v=%b wr=%b rd=%0d data=%h rdy=%b expected v=1 wr=1 rd=9 data=0000cafe rdy=0",
                         i, m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data, e2m_rdy); end
            step();
        end
        m2w_rdy = 1'b1;
        #1;
        tests++; if (e2m_rdy !== 1'b0) begin fails++; $display("FAIL halt_rdy: got %b expected 0", e2m_rdy); end
        step();
        tests++; if ({m2w_valid, e2m_rdy} !== 2'b00) begin fails++; $display("FAIL halt_idle: got v=%b rdy=%b expected v=0 rdy=0", m2w_valid, e2m_rdy); end
        step();
        tests++; if (m2w_valid !== 1'b0) begin fails++; $display("FAIL halt_noacc: m2w_valid got %b expected 0", m2w_valid); end
        cpu_halt = 1'b0;
        #1;
        tests++; if (e2m_rdy !== 1'b1) begin fails++; $display("FAIL unhalt_rdy: got %b expected 1", e2m_rdy); end
        step();
        tests++; if ({m2w_valid, m2w_Rd_addr, m2w_Rd_data} !== {1'b1, 5'd10, 32'h0000_1111}) begin fails++;
            $display("FAIL unhalt_out: got v=%b rd=%0d data=%h expected v=1 rd=10 data=00001111", m2w_valid, m2w_Rd_addr, m2w_Rd_data); end
        clear_e2m();
        step();
        $display("[TB] stall and halt checked");
    endtask

    task automatic test_reset_in_req();
        m2w_rdy = 1'b1;
        drive(1'b1, 5'd3, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0);
        step();
        clear_e2m();
        tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rstreq_req: got %b expected 1", dmem_req); end
        reset_in = 1'b0;
        step();
        tests++; if ({dmem_req, m2w_valid, e2m_rdy} !== 3'b000) begin fails++;
            $display("FAIL rstreq_abort: got req=%b v=%b rdy=%b expected all 0", dmem_req, m2w_valid, e2m_rdy); end
        reset_in   = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        step();
        tests++; if ({dmem_req, m2w_valid, m2w_Rd_data} !== 34'h0) begin fails++;
            $display("FAIL rstreq_lateack: got req=%b v=%b data=%h expected req=0 v=0 data=0", dmem_req, m2w_valid, m2w_Rd_data); end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        step();
        tests++; if (m2w_valid !== 1'b0) begin fails++; $display("FAIL rstreq_idle: m2w_valid got %b expected 0", m2w_valid); end
        $display("[TB] reset during REQ checked");
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        m2w_rdy = 1'b1;
        drive(1'b1, 5'd6, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
        step();
        clear_e2m();
        for (int i = 0; i < 4; i++) begin
            tests++; if ({dmem_req, bus_err} !== 2'b10) begin fails++;
                $display("FAIL tmo_wait%0d: got req=%b err=%b expected req=1 err=0", i, dmem_req, bus_err); end
            step();
        end
        tests++; if ({bus_err, m2w_valid, m2w_Rd_wr, dmem_req} !== 4'b1100) begin fails++;
            $display("FAIL tmo_abort: got err=%b v=%b wr=%b req=%b expected err=1 v=1 wr=0 req=0", bus_err, m2w_valid, m2w_Rd_wr, dmem_req); end
        step();
        tests++; if ({bus_err, m2w_valid} !== 2'b00) begin fails++;
            $display("FAIL tmo_after: got err=%b v=%b expected 0 0", bus_err, m2w_valid); end
        $display("[TB] timeout checked");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in   = 1'b0;
        cpu_halt   = 1'b0;
        m2w_rdy    = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        clear_e2m();
        step();

        test_reset();
        test_alu();
        test_load("lb",     2'd0, 1'b0, 32'h0000_0103, 32'h80AA_BBCC, 3, 32'h0000_0100, 4'b1000, 32'hFFFF_FF80);
        test_load("lbu",    2'd0, 1'b1, 32'h0000_0103, 32'h80AA_BBCC, 3, 32'h0000_0100, 4'b1000, 32'h0000_0080);
        test_load("lb_pos", 2'd0, 1'b0, 32'h0000_0101, 32'h0000_7F00, 1, 32'h0000_0100, 4'b0010, 32'h0000_007F);
        test_load("lh",     2'd1, 1'b0, 32'h0000_0102, 32'h80AA_BBCC, 1, 32'h0000_0100, 4'b1100, 32'hFFFF_80AA);
        test_load("lhu",    2'd1, 1'b1, 32'h0000_0100, 32'h1234_F00D, 1, 32'h0000_0100, 4'b0011, 32'h0000_F00D);
        test_load("lw",     2'd2, 1'b0, 32'h0000_010C, 32'hCAFE_BABE, 2, 32'h0000_010C, 4'b1111, 32'hCAFE_BABE);
        test_store("sh", 2'd1, 32'h0000_0202, 32'h0000_BEEF, 1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
        test_store("sb", 2'd0, 32'h0000_0101, 32'h1234_5678, 2, 32'h0000_0100, 4'b0010, 32'h7878_7878);
        test_store("sw", 2'd2, 32'h0000_0204, 32'hA1B2_C3D4, 1, 32'h0000_0204, 4'b1111, 32'hA1B2_C3D4);
        test_misalign("lw_mis", 2'd2, 32'h0000_0301);
        test_misalign("lh_mis", 2'd1, 32'h0000_0103);
        test_stall_halt();
        test_reset_in_req();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the RisKy1 5-stage pipeline. Sits between Execute and Writeback and drives the M2W signals that WB consumes.
- Accepts one instruction at a time from Execute over a valid/rdy handshake.
- Performs load/store transactions on a req/ack data-memory port, including byte-lane steering and load sign/zero extension.
- Presents a single-entry M2W output register to WB.

Parameters:
- RSZ, 32, register/data width; only 32 is supported, any other value triggers $fatal at elaboration.
- MAX_GPR, 32, number of GPRs; must be 16 or 32, otherwise $fatal.
- DMEM_TIMEOUT, 255, maximum cycles in REQ before abort; used only with the optional feature; 8-bit counter.

Ports:
- clk_in  input  1  clock; all logic on the rising edge.
- reset_in  input  1  synchronous, active-low reset.
- cpu_halt  input  1  when high, no new instruction is accepted.
- e2m_valid  input  1  Execute has an instruction.
- e2m_rdy  output  1  stage accepts the instruction this cycle.
- e2m_Rd_wr  input  1  instruction writes a GPR.
- e2m_Rd_addr  input  5  destination GPR.
- e2m_Rd_data  input  RSZ  ALU result.
- e2m_is_ld  input  1  load instruction.
- e2m_is_st  input  1  store instruction.
- e2m_size  input  2  access size: 0 = byte, 1 = half, 2 = word.
- e2m_unsigned  input  1  zero-extend loads (LBU/LHU).
- e2m_addr  input  RSZ  effective address.
- e2m_st_data  input  RSZ  store data, right-justified.
- dmem_req  output  1  data-memory request.
- dmem_we  output  1  write strobe.
- dmem_addr  output  RSZ  word address, bits [1:0] = 0.
- dmem_be  output  4  byte enables.
- dmem_wdata  output  RSZ  lane-replicated store data.
- dmem_ack  input  1  memory completes the request.
- dmem_rdata  input  RSZ  read word, valid with dmem_ack.
- m2w_valid  output  1  output register holds a result.
- m2w_rdy  input  1  WB accepts the result.
- m2w_Rd_wr  output  1  write GPR.
- m2w_Rd_addr  output  5  destination GPR.
- m2w_Rd_data  output  RSZ  write data.
- misalign  output  1  one-cycle pulse when a misaligned access is dropped.

Behaviour:
- Reset (reset_in = 0 on a rising edge):
  - State goes to IDLE.
  - These outputs are 0: m2w_valid, m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, misalign.
  - e2m_rdy is forced 0 combinationally while reset_in = 0.
- States: IDLE, REQ, OUT.
- e2m_rdy = reset_in & !cpu_halt & (IDLE | (OUT & m2w_rdy)). It is never high in REQ.
- Accept occurs when e2m_valid & e2m_rdy. At accept, all e2m fields are captured.
- Non-memory instruction:
  - Goes to OUT at the next edge; latency 1.
  - m2w_Rd_data = e2m_Rd_data and m2w_Rd_wr = e2m_Rd_wr.
  - Rd_addr = 0 is passed through unchanged.
- Misalignment rule:
  - Half access with addr[0] = 1, or word access with addr[1:0] != 0, is misaligned.
  - Misaligned access: no dmem request; goes to OUT with m2w_Rd_wr = 0; misalign pulses for one cycle.
- Aligned load or store:
  - Goes to REQ.
  - In REQ: dmem_req = 1; dmem_addr = {addr[31:2], 2'b00}; dmem_we = is_st.
  - dmem_be: byte = 1 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111.
  - dmem_wdata: byte = {4{st[7:0]}}; half = {2{st[15:0]}}; word = st.
  - dmem_addr, dmem_be, dmem_we and dmem_wdata are held stable until dmem_ack. dmem_req is held high until dmem_ack.
- On dmem_ack in REQ:
  - dmem_req drops at the next edge and the state goes to OUT.
  - Load: selects byte/half lane by addr[1:0], then sign- or zero-extends per e2m_unsigned. m2w_Rd_wr = e2m_Rd_wr.
  - Store: m2w_Rd_wr = 0, but m2w_valid is still asserted so WB retires the instruction.
  - Minimum load/store latency is 2 cycles (ack in the first REQ cycle).
- OUT state:
  - m2w_valid = 1; all m2w fields are held stable until m2w_rdy.
  - m2w_rdy with no new accept: go to IDLE; m2w_valid = 0 next cycle.
  - m2w_rdy with a new accept in the same cycle: back-to-back, no bubble for non-memory instructions.
- dmem_ack outside REQ is ignored.
- cpu_halt only blocks new accepts. An in-flight REQ and a held OUT still complete.
- Reset during REQ: dmem_req is 0 the next cycle and the transaction is abandoned. A late ack is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches DMEM_TIMEOUT, the access is aborted: dmem_req drops and the state goes to OUT with m2w_Rd_wr = 0.
  - Output bus_err (1 bit) pulses for one cycle; it resets to 0.
- When not defined: no counter, no bus_err port, and REQ waits indefinitely for ack.

Test Plan:
- ADD result 0x0000_1234 to Rd = 5, m2w_rdy = 1 → one cycle later m2w_valid = 1, Rd_wr = 1, Rd_addr = 5, Rd_data = 0x0000_1234; e2m_rdy high every cycle in a back-to-back stream.
- LB at addr 0x103, dmem_rdata = 0x80AA_BBCC, ack after 3 cycles → dmem_addr = 0x100, be = 4'b1000, we = 0 held 3 cycles; Rd_data = 0xFFFF_FF80. With LBU the result is 0x0000_0080.
- SH at addr 0x202, st_data = 0x0000_BEEF → be = 4'b1100, wdata = 0xBEEF_BEEF, we = 1; m2w_valid = 1 with Rd_wr = 0.
- LW at addr 0x301 → no dmem_req, misalign = 1 for one cycle, m2w_valid = 1 with Rd_wr = 0.
- Result in OUT with m2w_rdy = 0 for 4 cycles, cpu_halt = 1 → m2w fields stable, e2m_rdy = 0 throughout; m2w_rdy = 1 → IDLE, and no accept while halt remains high.
- reset_in = 0 during REQ → dmem_req = 0 and m2w_valid = 0 next cycle; an ack arriving after reset produces no output. With DMEM_TIMEOUT_EN and DMEM_TIMEOUT = 4, no ack → bus_err pulses after 4 REQ cycles.
